// File: rtl/cpu_execute_stage.sv
// ----------------------------------------------------------------------------
// cpu_execute_stage
//
// Execute stage of the 5-stage pipeline. Takes the registered decode->execute
// bundle, resolves operand forwarding from the commit and writeback stages,
// computes the ALU result (or runs a multi-cycle multiply), resolves BEQ/JUMP
// and registers the execute->commit bundle together with a branch redirect.
//
// Ports
//   clock, reset            pipeline clock, asynchronous active-high reset
//   in_*                    decode->execute bundle (PC+4, operands, ids,
//                           offset, ALU op, MUL flag, control bits)
//   fwd_c_*                 commit-stage forwarding source
//   fwd_w_*                 writeback-stage forwarding source
//   out_*                   registered execute->commit bundle
//   branch_taken            registered one-cycle redirect strobe
//   branch_target           registered redirect address
//   ex_stall                combinational stall request to the hazard unit
// ----------------------------------------------------------------------------
module cpu_execute_stage #(
    parameter int MUL_LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] in_next_pc,
    input  logic [31:0] in_ra_data,
    input  logic [31:0] in_rb_data,
    input  logic [4:0]  in_ra_id,
    input  logic [4:0]  in_rb_id,
    input  logic [4:0]  in_reg_dest,
    input  logic [31:0] in_offset_data,
    input  logic        in_use_reg_b,
    input  logic [1:0]  in_alu_op,
    input  logic        in_is_mul,
    input  logic        in_branch,
    input  logic        in_jump,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_mem_to_reg,
    input  logic        in_reg_write,

    input  logic        fwd_c_reg_write,
    input  logic [4:0]  fwd_c_dest,
    input  logic [31:0] fwd_c_data,
    input  logic        fwd_w_reg_write,
    input  logic [4:0]  fwd_w_dest,
    input  logic [31:0] fwd_w_data,

    output logic [31:0] out_alu_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_reg_dest,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_mem_to_reg,
    output logic        out_reg_write,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        ex_stall
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

    localparam logic [1:0] ALU_ADD_OP = 2'b00;
    localparam logic [1:0] ALU_SUB_OP = 2'b01;
    localparam logic [1:0] ALU_AND_OP = 2'b10;
    localparam logic [1:0] ALU_OR_OP  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_b_q, mul_b_d;

    logic [31:0]      alu_result_q, alu_result_d;
    logic [31:0]      store_data_q, store_data_d;
    logic [4:0]       reg_dest_q, reg_dest_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             reg_write_q, reg_write_d;
    logic             branch_taken_q, branch_taken_d;
    logic [31:0]      branch_target_q, branch_target_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic        squash;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic [31:0] jump_target;
    logic [31:0] beq_target;
    logic        operands_equal;
    logic [31:0] mul_product;

    // Commit stage holds the younger value, so it takes priority over
    // writeback. r0 is hard-wired zero in the bank and is never forwarded.
    function automatic logic [31:0] fwd_select(
        input logic [4:0]  id,
        input logic [31:0] bank_data,
        input logic        c_we,
        input logic [4:0]  c_dest,
        input logic [31:0] c_data,
        input logic        w_we,
        input logic [4:0]  w_dest,
        input logic [31:0] w_data
    );
        logic [31:0] result;
        result = bank_data;
        if (id != 5'd0) begin
            if (c_we && (c_dest == id)) begin
                result = c_data;
            end else if (w_we && (w_dest == id)) begin
                result = w_data;
            end
        end
        return result;
    endfunction

    // The instruction sitting at the inputs while a redirect is on the
    // outputs was fetched down the wrong path.
    assign squash = branch_taken_q;

    assign fwd_a = fwd_select(in_ra_id, in_ra_data,
                              fwd_c_reg_write, fwd_c_dest, fwd_c_data,
                              fwd_w_reg_write, fwd_w_dest, fwd_w_data);
    assign fwd_b = fwd_select(in_rb_id, in_rb_data,
                              fwd_c_reg_write, fwd_c_dest, fwd_c_data,
                              fwd_w_reg_write, fwd_w_dest, fwd_w_data);

    assign op_b           = in_use_reg_b ? fwd_b : in_offset_data;
    assign operands_equal = (fwd_a == fwd_b);
    assign jump_target    = fwd_a + in_offset_data;
    assign beq_target     = in_next_pc + in_offset_data;

    // Operands are frozen in mul_a_q/mul_b_q for the whole busy window, so
    // the product is a stable multi-cycle path; only the low word is kept.
    assign mul_product = mul_a_q * mul_b_q;

    always_comb begin
        alu_out = fwd_a + op_b;
        case (in_alu_op)
            ALU_ADD_OP: alu_out = fwd_a + op_b;
            ALU_SUB_OP: alu_out = fwd_a - op_b;
            ALU_AND_OP: alu_out = fwd_a & op_b;
            ALU_OR_OP:  alu_out = fwd_a | op_b;
            default:    alu_out = fwd_a + op_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Default: bubble. Control bits drop to zero, data fields hold.
        state_d         = state_q;
        cnt_d           = cnt_q;
        mul_a_d         = mul_a_q;
        mul_b_d         = mul_b_q;
        alu_result_d    = alu_result_q;
        store_data_d    = store_data_q;
        reg_dest_d      = reg_dest_q;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        reg_write_d     = 1'b0;
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;
        ex_stall        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (squash) begin
                    // Wrong-path instruction: emit a bubble, start nothing.
                    state_d = ST_IDLE;
                end else if (in_is_mul) begin
                    mul_a_d  = fwd_a;
                    mul_b_d  = fwd_b;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_MUL_BUSY;
                    ex_stall = 1'b1;
                end else begin
                    alu_result_d = alu_out;
                    store_data_d = fwd_b;
                    reg_dest_d   = in_reg_dest;
                    mem_read_d   = in_mem_read;
                    mem_write_d  = in_mem_write;
                    mem_to_reg_d = in_mem_to_reg;
                    reg_write_d  = in_reg_write;
                    if (in_branch && (in_jump || operands_equal)) begin
                        branch_taken_d  = 1'b1;
                        branch_target_d = in_jump ? jump_target : beq_target;
                    end
                end
            end

            ST_MUL_BUSY: begin
                if (cnt_q != CNT_LAST) begin
                    ex_stall = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    // Stall drops this cycle, so decode advances past the
                    // held MUL; it is consumed here rather than restarted.
                    alu_result_d = mul_product;
                    reg_dest_d   = in_reg_dest;
                    reg_write_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            mul_a_q         <= '0;
            mul_b_q         <= '0;
            alu_result_q    <= '0;
            store_data_q    <= '0;
            reg_dest_q      <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_write_q     <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mul_a_q         <= mul_a_d;
            mul_b_q         <= mul_b_d;
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            reg_dest_q      <= reg_dest_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            reg_write_q     <= reg_write_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign out_alu_result = alu_result_q;
    assign out_store_data = store_data_q;
    assign out_reg_dest   = reg_dest_q;
    assign out_mem_read   = mem_read_q;
    assign out_mem_write  = mem_write_q;
    assign out_mem_to_reg = mem_to_reg_q;
    assign out_reg_write  = reg_write_q;
    assign branch_taken   = branch_taken_q;
    assign branch_target  = branch_target_q;

endmodule

// File: tb/tb_cpu_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_cpu_execute_stage
//
// Self-checking bench for cpu_execute_stage: directed scenarios followed by
// randomized instructions, each compared against an instruction-level model
// (forwarding rules, ALU arithmetic, branch rules, MUL timing).
// ----------------------------------------------------------------------------
module tb_cpu_execute_stage;

    localparam int MUL_LATENCY = 5;

    logic        clock;
    logic        reset;
    logic [31:0] in_next_pc;
    logic [31:0] in_ra_data, in_rb_data;
    logic [4:0]  in_ra_id, in_rb_id, in_reg_dest;
    logic [31:0] in_offset_data;
    logic        in_use_reg_b;
    logic [1:0]  in_alu_op;
    logic        in_is_mul, in_branch, in_jump;
    logic        in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write;
    logic        fwd_c_reg_write, fwd_w_reg_write;
    logic [4:0]  fwd_c_dest, fwd_w_dest;
    logic [31:0] fwd_c_data, fwd_w_data;
    logic [31:0] out_alu_result, out_store_data;
    logic [4:0]  out_reg_dest;
    logic        out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ex_stall;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    logic exp_taken = 1'b0;   // model: redirect pending on the outputs

    cpu_execute_stage #(.MUL_LATENCY(MUL_LATENCY)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_next_pc     (in_next_pc),
        .in_ra_data     (in_ra_data),
        .in_rb_data     (in_rb_data),
        .in_ra_id       (in_ra_id),
        .in_rb_id       (in_rb_id),
        .in_reg_dest    (in_reg_dest),
        .in_offset_data (in_offset_data),
        .in_use_reg_b   (in_use_reg_b),
        .in_alu_op      (in_alu_op),
        .in_is_mul      (in_is_mul),
        .in_branch      (in_branch),
        .in_jump        (in_jump),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .fwd_c_reg_write(fwd_c_reg_write),
        .fwd_c_dest     (fwd_c_dest),
        .fwd_c_data     (fwd_c_data),
        .fwd_w_reg_write(fwd_w_reg_write),
        .fwd_w_dest     (fwd_w_dest),
        .fwd_w_data     (fwd_w_data),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_reg_dest   (out_reg_dest),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .ex_stall       (ex_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_fwd(input logic [4:0] id, input logic [31:0] bank);
        if (id == 5'd0) return bank;
        if (fwd_c_reg_write && fwd_c_dest == id) return fwd_c_data;
        if (fwd_w_reg_write && fwd_w_dest == id) return fwd_w_data;
        return bank;
    endfunction

    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic set_nop();
        in_next_pc = 0; in_ra_data = 0; in_rb_data = 0;
        in_ra_id = 0; in_rb_id = 0; in_reg_dest = 0; in_offset_data = 0;
        in_use_reg_b = 0; in_alu_op = 0; in_is_mul = 0; in_branch = 0; in_jump = 0;
        in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0; in_reg_write = 0;
        fwd_c_reg_write = 0; fwd_c_dest = 0; fwd_c_data = 0;
        fwd_w_reg_write = 0; fwd_w_dest = 0; fwd_w_data = 0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_reg_write"}, out_reg_write, 0);
        check({tag, "_mem_read"},  out_mem_read, 0);
        check({tag, "_mem_write"}, out_mem_write, 0);
        check({tag, "_mem_to_reg"}, out_mem_to_reg, 0);
        check({tag, "_taken"}, branch_taken, 0);
    endtask

    // Inputs are already driven (shortly after a rising edge). Runs the
    // instruction through and leaves time just after the edge on which its
    // result is registered.
    task automatic run_instr();
        logic [31:0] a, b, opb, res, tgt;
        logic [63:0] prod;
        logic        squash, start_mul, taken;
        squash    = exp_taken;
        a         = model_fwd(in_ra_id, in_ra_data);
        b         = model_fwd(in_rb_id, in_rb_data);
        opb       = in_use_reg_b ? b : in_offset_data;
        start_mul = in_is_mul && !squash;
        #1;
        check("stall_issue", ex_stall, start_mul);
        if (start_mul) begin
            for (int k = 1; k < MUL_LATENCY; k++) begin
                @(posedge clock); #1;
                // forwarding sources change while busy; must be ignored
                fwd_c_reg_write = 1; fwd_c_dest = in_ra_id; fwd_c_data = $urandom;
                fwd_w_reg_write = 1; fwd_w_dest = in_rb_id; fwd_w_data = $urandom;
                #1;
                check_bubble("mul_wait");
                check("mul_stall", ex_stall, (k < MUL_LATENCY - 1) ? 1 : 0);
            end
        end
        @(posedge clock); #1;
        txn++;
        if (squash) begin
            $display("txn %0d squashed", txn);
            check_bubble("squash");
            exp_taken = 0;
        end else if (start_mul) begin
            prod = 64'(a) * 64'(b);
            $display("txn %0d MUL %08h*%08h -> %08h", txn, a, b, out_alu_result);
            check("mul_result", out_alu_result, prod[31:0]);
            check("mul_dest", out_reg_dest, in_reg_dest);
            check("mul_reg_write", out_reg_write, 1);
            check("mul_mem_read", out_mem_read, 0);
            check("mul_mem_write", out_mem_write, 0);
            check("mul_mem_to_reg", out_mem_to_reg, 0);
            check("mul_taken", branch_taken, 0);
            exp_taken = 0;
        end else begin
            res   = model_alu(in_alu_op, a, opb);
            taken = in_branch && (in_jump || a == b);
            tgt   = in_jump ? a + in_offset_data : in_next_pc + in_offset_data;
            $display("txn %0d op=%0d br=%0b j=%0b res=%08h taken=%0b", txn, in_alu_op,
                     in_branch, in_jump, out_alu_result, branch_taken);
            check("alu_result", out_alu_result, res);
            check("store_data", out_store_data, b);
            check("reg_dest", out_reg_dest, in_reg_dest);
            check("reg_write", out_reg_write, in_reg_write);
            check("mem_read", out_mem_read, in_mem_read);
            check("mem_write", out_mem_write, in_mem_write);
            check("mem_to_reg", out_mem_to_reg, in_mem_to_reg);
            check("taken", branch_taken, taken);
            if (taken) check("target", branch_target, tgt);
            exp_taken = taken;
        end
    endtask

    task automatic rand_instr();
        int kind;
        set_nop();
        kind           = $urandom_range(0, 9);
        in_next_pc     = $urandom & 32'hFFFF_FFFC;
        in_ra_id       = 5'($urandom_range(0, 7));
        in_rb_id       = ($urandom_range(0, 1) == 1) ? in_ra_id : 5'($urandom_range(0, 7));
        in_ra_data     = (in_ra_id == 0) ? 0 : $urandom;
        in_rb_data     = (in_rb_id == in_ra_id) ? in_ra_data : (in_rb_id == 0 ? 0 : $urandom);
        in_offset_data = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)));
        in_reg_dest    = 5'($urandom_range(1, 31));
        fwd_c_reg_write = 1'($urandom_range(0, 1));
        fwd_c_dest      = 5'($urandom_range(0, 7));
        fwd_c_data      = $urandom;
        fwd_w_reg_write = 1'($urandom_range(0, 1));
        fwd_w_dest      = 5'($urandom_range(0, 7));
        fwd_w_data      = $urandom;
        case (kind)
            0, 1, 2, 3, 4: begin
                in_use_reg_b = 1'($urandom_range(0, 1));
                in_alu_op    = 2'($urandom_range(0, 3));
                in_reg_write = 1;
            end
            5: begin in_mem_read = 1; in_mem_to_reg = 1; in_reg_write = 1; end
            6: begin in_mem_write = 1; end
            7: begin in_branch = 1; end
            8: begin in_branch = 1; in_jump = 1; end
            default: begin in_is_mul = 1; in_use_reg_b = 1; in_reg_write = 1; end
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1;
        set_nop();
        repeat (2) @(posedge clock);
        #1;
        check("rst_alu_result", out_alu_result, 0);
        check("rst_reg_write", out_reg_write, 0);
        check("rst_taken", branch_taken, 0);
        check("rst_target", branch_target, 0);
        check("rst_stall", ex_stall, 0);
        reset = 0;

        // ADD r3 with both forwarding sources hitting: commit wins
        set_nop();
        in_ra_id = 3; in_rb_id = 4; in_rb_data = 5; in_use_reg_b = 1;
        in_reg_dest = 5; in_reg_write = 1;
        fwd_c_reg_write = 1; fwd_c_dest = 3; fwd_c_data = 10;
        fwd_w_reg_write = 1; fwd_w_dest = 3; fwd_w_data = 99;
        run_instr();
        check("t_add_result", out_alu_result, 15);
        check("t_add_reg_write", out_reg_write, 1);

        // ADDI from r0: no forwarding from register 0
        set_nop();
        in_offset_data = 32'hFFFF_FFFC; in_reg_dest = 6; in_reg_write = 1;
        fwd_c_reg_write = 1; fwd_c_dest = 0; fwd_c_data = 7;
        run_instr();
        check("t_addi_r0", out_alu_result, 32'hFFFF_FFFC);

        // BEQ taken, then the wrong-path ADD becomes a bubble
        set_nop();
        in_ra_id = 1; in_rb_id = 2; in_ra_data = 4; in_rb_data = 4; in_use_reg_b = 1;
        in_next_pc = 32'h100; in_offset_data = 32'h20; in_branch = 1;
        run_instr();
        check("t_beq_taken", branch_taken, 1);
        check("t_beq_target", branch_target, 32'h120);
        set_nop();
        in_ra_id = 1; in_ra_data = 1; in_offset_data = 1; in_reg_dest = 7; in_reg_write = 1;
        run_instr();
        check("t_squash_reg_write", out_reg_write, 0);
        set_nop();
        in_ra_id = 1; in_rb_id = 2; in_ra_data = 4; in_rb_data = 5; in_use_reg_b = 1;
        in_next_pc = 32'h100; in_offset_data = 32'h20; in_branch = 1;
        run_instr();
        check("t_beq_not_taken", branch_taken, 0);

        // JUMP: one-cycle redirect pulse
        set_nop();
        in_ra_id = 9; in_ra_data = 32'h400; in_offset_data = 8; in_branch = 1; in_jump = 1;
        run_instr();
        check("t_jump_taken", branch_taken, 1);
        check("t_jump_target", branch_target, 32'h408);
        set_nop();
        run_instr();
        check("t_jump_pulse", branch_taken, 0);

        // MUL
        set_nop();
        in_ra_id = 1; in_rb_id = 2; in_ra_data = 6; in_rb_data = 7; in_use_reg_b = 1;
        in_is_mul = 1; in_reg_dest = 8; in_reg_write = 1;
        run_instr();
        check("t_mul_42", out_alu_result, 42);
        set_nop();
        in_ra_id = 1; in_rb_id = 2; in_ra_data = 32'hFFFF_FFFF; in_rb_data = 2; in_use_reg_b = 1;
        in_is_mul = 1; in_reg_dest = 9; in_reg_write = 1;
        run_instr();
        check("t_mul_wrap", out_alu_result, 32'hFFFF_FFFE);

        // Reset in the middle of a MUL
        set_nop();
        in_ra_id = 1; in_ra_data = 32'h55; in_reg_dest = 3; in_reg_write = 1;
        run_instr();
        set_nop();
        in_ra_id = 1; in_rb_id = 2; in_ra_data = 3; in_rb_data = 5; in_use_reg_b = 1;
        in_is_mul = 1; in_reg_dest = 4; in_reg_write = 1;
        #1 check("t_rst_mul_stall", ex_stall, 1);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        #1;
        check("t_rst_alu_result", out_alu_result, 0);
        check("t_rst_reg_dest", out_reg_dest, 0);
        check("t_rst_reg_write", out_reg_write, 0);
        check("t_rst_taken", branch_taken, 0);
        check("t_rst_target", branch_target, 0);
        @(posedge clock); #1;
        reset = 0;
        exp_taken = 0;
        set_nop();
        #1 check("t_rst_stall_after", ex_stall, 0);
        for (int i = 0; i < MUL_LATENCY + 2; i++) begin
            set_nop();
            run_instr();
            check("t_rst_no_mul_result", out_reg_write, 0);
        end

        // LDW
        set_nop();
        in_ra_id = 2; in_ra_data = 32'h1000; in_offset_data = 12; in_reg_dest = 10;
        in_mem_read = 1; in_mem_to_reg = 1; in_reg_write = 1;
        run_instr();
        check("t_ldw_addr", out_alu_result, 32'h100C);
        check("t_ldw_mem_read", out_mem_read, 1);
        check("t_ldw_mem_to_reg", out_mem_to_reg, 1);

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            rand_instr();
            run_instr();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
